// File: rtl/pwm_multi_pkg.sv
// pwm_multi shared definitions.
// Register addresses, CTRL bit positions and counter enums.
package pwm_multi_pkg;

    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_PERIOD = 1;
    localparam int ADDR_PRESC  = 2;
    localparam int ADDR_POL    = 3;
    localparam int ADDR_DUTY0  = 4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_MODE   = 1;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_multi_cmp_chan.sv
// One PWM compare channel.
// Active duty copy, compare against the shared counter, polarity, output flop.
module pwm_cmp_chan
    import pwm_multi_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] duty_sh_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             en_i,
    input  logic             pol_i,
    output logic             pwm_o
);

    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;

    // Next duty copy and next output level.
    always_comb begin
        duty_d = load_i ? duty_sh_i : duty_q;
        pwm_d  = en_i ? ((cnt_i < duty_q) ^ pol_i) : pol_i;
    end

    // Channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled timebase, edge/center counting.
// Shadowed period/duty reload on the period boundary.
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [NCH-1:0]    pwm_o,
    output logic              period_tick
);

    logic               en_q, en_d;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   per_sh_q, per_sh_d;
    logic [CNT_W-1:0]   per_act_q, per_act_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [NCH-1:0]     pol_q, pol_d;
    logic [CNT_W-1:0]   duty_sh_q [NCH];
    logic [CNT_W-1:0]   duty_sh_d [NCH];
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    dir_e               dir_q, dir_d;
    logic               tick_q;

    logic mode_chg;
    logic clr;
    logic tick;
    logic evt;
    logic load;

    // Register-file write decode; shadows and immediate regs.
    always_comb begin
        en_d      = en_q;
        mode_d    = mode_q;
        per_sh_d  = per_sh_q;
        presc_d   = presc_q;
        pol_d     = pol_q;
        duty_sh_d = duty_sh_q;
        mode_chg  = 1'b0;
        if (wr_en) begin
            if (wr_addr == ADDR_W'(ADDR_CTRL)) begin
                en_d     = wr_data[CTRL_EN];
                mode_d   = mode_e'(wr_data[CTRL_MODE]);
                mode_chg = (mode_d != mode_q);
            end
            if (wr_addr == ADDR_W'(ADDR_PERIOD)) begin
                per_sh_d = wr_data;
            end
            if (wr_addr == ADDR_W'(ADDR_PRESC)) begin
                presc_d = PRESC_W'(wr_data);
            end
            if (wr_addr == ADDR_W'(ADDR_POL)) begin
                pol_d = NCH'(wr_data);
            end
            for (int i = 0; i < NCH; i++) begin
                if (wr_addr == ADDR_W'(ADDR_DUTY0 + i)) begin
                    duty_sh_d[i] = wr_data;
                end
            end
        end
    end

    // Disable or a mode switch restarts the timebase from the bottom.
    assign clr  = !en_d || mode_chg;
    assign tick = en_q && !clr && (pcnt_q >= presc_q);

    // Prescaler, up/down counter and update-event detection.
    always_comb begin
        evt    = 1'b0;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        pcnt_d = pcnt_q + PRESC_W'(1);
        if (clr || !en_q) begin
            pcnt_d = '0;
            cnt_d  = '0;
            dir_d  = DIR_UP;
        end else if (tick) begin
            pcnt_d = '0;
            if (mode_q == MODE_EDGE) begin
                if (cnt_q >= per_act_q) begin
                    evt   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (per_act_q == '0) begin
                evt   = 1'b1;
                cnt_d = '0;
                dir_d = DIR_DOWN;
            end else if (dir_q == DIR_UP) begin
                if (cnt_q >= per_act_q) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (cnt_q == '0) begin
                evt   = 1'b1;
                cnt_d = CNT_W'(1);
                dir_d = DIR_UP;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // While disabled the active copies follow the shadows.
    assign load      = evt || !en_q;
    assign per_act_d = load ? per_sh_q : per_act_q;

    // Configuration and timebase state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            mode_q    <= MODE_EDGE;
            per_sh_q  <= '1;
            per_act_q <= '1;
            presc_q   <= '0;
            pol_q     <= '0;
            duty_sh_q <= '{default: '0};
            pcnt_q    <= '0;
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            tick_q    <= 1'b0;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            per_sh_q  <= per_sh_d;
            per_act_q <= per_act_d;
            presc_q   <= presc_d;
            pol_q     <= pol_d;
            duty_sh_q <= duty_sh_d;
            pcnt_q    <= pcnt_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            tick_q    <= evt;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pwm_cmp_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load),
            .duty_sh_i (duty_sh_q[i]),
            .cnt_i     (cnt_q),
            .en_i      (en_d),
            .pol_i     (pol_d[i]),
            .pwm_o     (pwm_o[i])
        );
    end

    assign period_tick = tick_q;

endmodule
